corr_snapshot_writer: RTL and testbench
=======================================

Name: corr_snapshot_writer

Overview:
- PL-side write end of the four correlator result BRAMs (aa, bb, ab_re, ab_im) that the PS reads over AXI-lite.
- Takes the accumulator output stream (one 4-tuple per accumulation), saturates each word to the BRAM width and writes it at an incrementing address.
- Capture is armed per snapshot (one-shot) or runs free with wrap-around (continuous), and reports completion back to the control registers.

Parameters:
- DIN_WIDTH, 64, width of each signed accumulator output word.
- DOUT_WIDTH, 32, BRAM word width; must be <= DIN_WIDTH.
- ADDR_WIDTH, 7, BRAM address width; depth = 2^ADDR_WIDTH.
- DATA_TYPE, "signed", "signed" or "unsigned". Applies to all four channels for saturation (aa/bb powers are instantiated unsigned when required).

Ports:
- clk  in  1  system clock; everything is synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  single-cycle pulse that starts or restarts a capture.
- continuous  in  1  1 = wrap and keep writing; 0 = stop after n_samples. Sampled on arm.
- n_samples  in  ADDR_WIDTH+1  words per snapshot. Sampled on arm.
- din_aa, din_bb, din_ab_re, din_ab_im  in  DIN_WIDTH each  accumulator outputs.
- din_valid  in  1  qualifies all four din words.
- bram_addr  out  ADDR_WIDTH  write address, common to all four BRAMs.
- bram_we  out  1  write enable.
- bram_aa, bram_bb, bram_ab_re, bram_ab_im  out  DOUT_WIDTH each  saturated write data.
- busy  out  1  high while in CAPTURE.
- done  out  1  one-shot: level, high in DONE. Continuous: 1-cycle pulse on each wrap.
- wr_count  out  ADDR_WIDTH+1  words written in the current snapshot.
- sat_warning  out  1  sticky; set by any saturation and cleared on arm.

Behaviour:
- Reset, async on rst_n low:
  - State = IDLE.
  - bram_addr = 0, bram_we = 0, all bram_* data = 0.
  - busy = 0, done = 0, wr_count = 0, sat_warning = 0.
  - Latched n_samples and continuous = 0.
  - Reset mid-capture abandons the capture immediately; no further writes occur.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE --arm--> CAPTURE.
  - CAPTURE --last write, continuous=0--> DONE.
  - CAPTURE --last write, continuous=1--> CAPTURE (address wraps).
  - DONE --arm--> CAPTURE.
  - arm in CAPTURE restarts the capture: address and count go to 0, and the parameters are re-latched.
- On arm:
  - Latch n_samples as N. N = 0 or N > 2^ADDR_WIDTH is treated as 2^ADDR_WIDTH.
  - Clear wr_count, next address and sat_warning. done drops the next cycle.
  - A din_valid in the same cycle as arm is discarded.
- Write path, latency 1:
  - din_valid in CAPTURE at cycle t gives bram_we = 1 at t+1, with bram_addr = write index and data = saturated inputs.
  - bram_we is never high for more than one cycle per din_valid.
  - din_valid in IDLE or DONE is ignored (bram_we stays 0).
- Indexing:
  - Write index starts at 0 and increments after each accepted sample.
  - The sample with index N-1 is the last one.
  - wr_count updates together with bram_we and equals index+1.
  - In continuous mode wr_count returns to 1 on the first write after the wrap.
- done timing:
  - One-shot: done rises in the same cycle as the last bram_we and holds until the next arm.
  - Continuous: done pulses for one cycle, coincident with the bram_we at address N-1.
- Saturation, per channel:
  - signed: values > 2^(DOUT_WIDTH-1)-1 clamp to that value; values < -2^(DOUT_WIDTH-1) clamp to that value.
  - unsigned: values > 2^DOUT_WIDTH-1 clamp to 2^DOUT_WIDTH-1.
  - Bits are the low DOUT_WIDTH bits with no point shift; alignment is done upstream.
  - Any clamp sets sat_warning in the same cycle as bram_we.
- Back-to-back din_valid every cycle must be sustained with no loss.

Test Plan:
- Reset state: pulse rst_n low mid-cycle with din_valid high -> all outputs 0 asynchronously, and no bram_we after release until arm.
- One-shot capture: arm with n_samples=4, continuous=0, then 6 consecutive din_valid carrying aa=1..6 -> 4 writes at addr 0..3 with aa 1..4; done=1 coincident with the addr-3 write; valids 5 and 6 ignored; wr_count=4.
- Continuous wrap: arm with n_samples=3, continuous=1, then 7 valids -> addresses 0,1,2,0,1,2,0; done pulses exactly twice, one cycle each; busy stays 1.
- Saturation: DIN_WIDTH=64, DOUT_WIDTH=32, signed:
  - ab_re = 2^40 -> 0x7FFFFFFF; ab_im = -2^40 -> 0x80000000; sat_warning=1.
  - Next arm clears sat_warning.
- Restart and boundaries:
  - Re-arm after 2 of 8 writes -> next write at addr 0, wr_count=1.
  - n_samples=0 with ADDR_WIDTH=7 -> 128 writes, then done.
  - arm coinciding with din_valid -> that sample is not written.
- Gapped input: valid every 3rd cycle, n_samples=5 -> bram_we exactly one cycle after each valid; addresses are contiguous 0..4.

Source files
------------

// File: rtl/corr_snapshot_writer.sv
// Write side of the four correlator result BRAMs: saturates each accumulator word
// to BRAM width and writes it at an incrementing address, one-shot or wrapping.

module corr_sat #(
    parameter int DIN_WIDTH  = 64,
    parameter int DOUT_WIDTH = 32,
    parameter bit IS_SIGNED  = 1'b1
) (
    input  logic [DIN_WIDTH-1:0]  din_i,
    output logic [DOUT_WIDTH-1:0] dout_o,
    output logic                  sat_o
);
    logic [DIN_WIDTH-1:0] hi;

    // Word fits iff everything above the kept field is a pure sign (or zero) extension.
    always_comb begin
        if (IS_SIGNED) begin
            hi     = $signed(din_i) >>> (DOUT_WIDTH - 1);
            sat_o  = !((hi == '0) || (hi == '1));
            dout_o = sat_o ? {din_i[DIN_WIDTH-1], {(DOUT_WIDTH-1){~din_i[DIN_WIDTH-1]}}}
                           : din_i[DOUT_WIDTH-1:0];
        end else begin
            hi     = din_i >> DOUT_WIDTH;
            sat_o  = |hi;
            dout_o = sat_o ? '1 : din_i[DOUT_WIDTH-1:0];
        end
    end
endmodule

module corr_snapshot_writer #(
    parameter int    DIN_WIDTH  = 64,
    parameter int    DOUT_WIDTH = 32,
    parameter int    ADDR_WIDTH = 7,
    parameter string DATA_TYPE  = "signed"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  continuous,
    input  logic [ADDR_WIDTH:0]   n_samples,
    input  logic [DIN_WIDTH-1:0]  din_aa,
    input  logic [DIN_WIDTH-1:0]  din_bb,
    input  logic [DIN_WIDTH-1:0]  din_ab_re,
    input  logic [DIN_WIDTH-1:0]  din_ab_im,
    input  logic                  din_valid,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_we,
    output logic [DOUT_WIDTH-1:0] bram_aa,
    output logic [DOUT_WIDTH-1:0] bram_bb,
    output logic [DOUT_WIDTH-1:0] bram_ab_re,
    output logic [DOUT_WIDTH-1:0] bram_ab_im,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  sat_warning
);
    localparam bit                IS_SIGNED = (DATA_TYPE == "signed");
    localparam int                NUM_CH    = 4;
    localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

    state_t state_q, state_d;

    logic [NUM_CH-1:0][DIN_WIDTH-1:0]  din_vec;
    logic [NUM_CH-1:0][DOUT_WIDTH-1:0] dout_vec;
    logic [NUM_CH-1:0][DOUT_WIDTH-1:0] data_q;
    logic [NUM_CH-1:0]                 sat_vec;

    logic [ADDR_WIDTH:0]   n_q, idx_q, wr_count_q, n_eff;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  cont_q, we_q, wrap_q, sat_q;
    logic                  accept, last;

    assign din_vec = {din_ab_im, din_ab_re, din_bb, din_aa};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        corr_sat #(
            .DIN_WIDTH (DIN_WIDTH),
            .DOUT_WIDTH(DOUT_WIDTH),
            .IS_SIGNED (IS_SIGNED)
        ) u_sat (
            .din_i (din_vec[g]),
            .dout_o(dout_vec[g]),
            .sat_o (sat_vec[g])
        );
    end

    // A sample arriving together with arm belongs to the abandoned snapshot.
    assign accept = din_valid && !arm && (state_q == S_CAPTURE);
    assign last   = (idx_q == n_q - 1'b1);
    assign n_eff  = ((n_samples == '0) || (n_samples > DEPTH)) ? DEPTH : n_samples;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (arm) state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (arm)                            state_d = S_CAPTURE;
                else if (accept && last && !cont_q) state_d = S_DONE;
            end
            S_DONE:    if (arm) state_d = S_CAPTURE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_CAPTURE);
        done = (state_q == S_DONE) || wrap_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q        <= '0;
            cont_q     <= 1'b0;
            idx_q      <= '0;
            wr_count_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            wrap_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            we_q   <= accept;
            wrap_q <= accept && last && cont_q;
            if (arm) begin
                n_q        <= n_eff;
                cont_q     <= continuous;
                idx_q      <= '0;
                wr_count_q <= '0;
                sat_q      <= 1'b0;
            end else if (accept) begin
                addr_q     <= idx_q[ADDR_WIDTH-1:0];
                data_q     <= dout_vec;
                wr_count_q <= idx_q + 1'b1;
                idx_q      <= last ? '0 : idx_q + 1'b1;
                if (|sat_vec) sat_q <= 1'b1;
            end
        end
    end

    assign bram_addr   = addr_q;
    assign bram_we     = we_q;
    assign bram_aa     = data_q[0];
    assign bram_bb     = data_q[1];
    assign bram_ab_re  = data_q[2];
    assign bram_ab_im  = data_q[3];
    assign wr_count    = wr_count_q;
    assign sat_warning = sat_q;
endmodule

// File: tb/tb_corr_snapshot_writer.sv
// Scoreboard bench for corr_snapshot_writer: expected writes are queued as samples
// are driven and matched against every bram_we seen by the monitor.

module tb_corr_snapshot_writer;
    logic        clk, rst_n, arm, continuous, din_valid;
    logic [7:0]  n_samples;
    logic [63:0] din_aa, din_bb, din_ab_re, din_ab_im;
    logic [6:0]  bram_addr;
    logic        bram_we, busy, done, sat_warning;
    logic [31:0] bram_aa, bram_bb, bram_ab_re, bram_ab_im;
    logic [7:0]  wr_count;

    corr_snapshot_writer #(
        .DIN_WIDTH(64), .DOUT_WIDTH(32), .ADDR_WIDTH(7), .DATA_TYPE("signed")
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .continuous(continuous),
        .n_samples(n_samples), .din_aa(din_aa), .din_bb(din_bb),
        .din_ab_re(din_ab_re), .din_ab_im(din_ab_im), .din_valid(din_valid),
        .bram_addr(bram_addr), .bram_we(bram_we), .bram_aa(bram_aa),
        .bram_bb(bram_bb), .bram_ab_re(bram_ab_re), .bram_ab_im(bram_ab_im),
        .busy(busy), .done(done), .wr_count(wr_count), .sat_warning(sat_warning)
    );

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] aa, bb, re, im;
        logic [7:0]  wrc;
        logic        done, sat;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;
    int   done_cnt = 0, busy_low = 0;
    bit   watch = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] satc(input logic signed [63:0] v);
        if (v > 64'sd2147483647)       return 32'h7FFF_FFFF;
        else if (v < -64'sd2147483648) return 32'h8000_0000;
        else                           return v[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int n, input bit cont);
        arm        = 1'b1;
        n_samples  = 8'(n);
        continuous = cont;
        step();
        arm = 1'b0;
    endtask

    task automatic send(input logic [63:0] aa, bb, re, im, input bit wr,
                        input int ea, input int ewc, input bit edone, input bit esat);
        exp_t e;
        din_aa = aa; din_bb = bb; din_ab_re = re; din_ab_im = im;
        din_valid = 1'b1;
        if (wr) begin
            e.addr = 7'(ea);
            e.aa   = satc(aa);
            e.bb   = satc(bb);
            e.re   = satc(re);
            e.im   = satc(im);
            e.wrc  = 8'(ewc);
            e.done = edone;
            e.sat  = esat;
            e.cyc  = cyc + 1;
            sbq.push_back(e);
        end
        step();
        din_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (watch) begin
            if (done)  done_cnt++;
            if (!busy) busy_low++;
        end
        if (bram_we) begin
            chk("we_expected", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                me = sbq.pop_front();
                chk("we_cycle", 64'(cyc),        64'(me.cyc));
                chk("addr",     64'(bram_addr),  64'(me.addr));
                chk("aa",       64'(bram_aa),    64'(me.aa));
                chk("bb",       64'(bram_bb),    64'(me.bb));
                chk("ab_re",    64'(bram_ab_re), 64'(me.re));
                chk("ab_im",    64'(bram_ab_im), 64'(me.im));
                chk("wr_count", 64'(wr_count),   64'(me.wrc));
                chk("done",     64'(done),       64'(me.done));
                chk("sat",      64'(sat_warning),64'(me.sat));
            end
        end
    end

    initial begin
        rst_n = 1'b1; arm = 1'b0; continuous = 1'b0; n_samples = '0; din_valid = 1'b0;
        din_aa = '0; din_bb = '0; din_ab_re = '0; din_ab_im = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_we",   64'(bram_we),     64'd0);
        chk("rst_addr", 64'(bram_addr),   64'd0);
        chk("rst_aa",   64'(bram_aa),     64'd0);
        chk("rst_busy", 64'(busy),        64'd0);
        chk("rst_done", 64'(done),        64'd0);
        chk("rst_wrc",  64'(wr_count),    64'd0);
        chk("rst_sat",  64'(sat_warning), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // valid before any arm must be ignored
        send(64'd77, 64'd1, 64'd1, 64'd1, 0, 0, 0, 0, 0);
        step();

        // one-shot, N=4, six valids
        do_arm(4, 0);
        for (int i = 1; i <= 6; i++)
            send(64'(i), 64'(3*i), 64'(-i), 64'(1000+i), i <= 4, i-1, i, i == 4, 0);
        step();
        chk("os_done_hold", 64'(done),     64'd1);
        chk("os_busy",      64'(busy),     64'd0);
        chk("os_wrc",       64'(wr_count), 64'd4);

        // continuous, N=3, seven valids
        do_arm(3, 1);
        chk("arm_done_drop", 64'(done), 64'd0);
        done_cnt = 0; busy_low = 0; watch = 1;
        for (int i = 0; i < 7; i++)
            send(64'(i+10), 64'(i), 64'(i), 64'(i), 1, i % 3, (i % 3) + 1, (i % 3) == 2, 0);
        step(); step();
        watch = 0;
        chk("cont_done_pulses", 64'(done_cnt), 64'd2);
        chk("cont_busy_low",    64'(busy_low), 64'd0);

        // saturation
        do_arm(4, 0);
        send(64'd5, 64'd7, 64'h0000_0100_0000_0000, 64'hFFFF_FF00_0000_0000, 1, 0, 1, 0, 1);
        send(64'hFFFF_FFFF_8000_0000, 64'h0000_0000_7FFF_FFFF, 64'd1, 64'd2, 1, 1, 2, 0, 1);
        step();
        chk("sat_sticky", 64'(sat_warning), 64'd1);
        do_arm(8, 0);
        chk("sat_clear_on_arm", 64'(sat_warning), 64'd0);
        chk("arm_wrc_clear",    64'(wr_count),    64'd0);

        // restart after 2 of 8, then arm coinciding with valid
        send(64'd21, 64'd0, 64'd0, 64'd0, 1, 0, 1, 0, 0);
        send(64'd22, 64'd0, 64'd0, 64'd0, 1, 1, 2, 0, 0);
        do_arm(8, 0);
        send(64'd23, 64'd0, 64'd0, 64'd0, 1, 0, 1, 0, 0);
        arm = 1'b1; n_samples = 8'd8; continuous = 1'b0;
        din_aa = 64'd99; din_valid = 1'b1;
        step();
        arm = 1'b0; din_valid = 1'b0;
        send(64'd42, 64'd0, 64'd0, 64'd0, 1, 0, 1, 0, 0);

        // n_samples = 0 -> full depth
        do_arm(0, 0);
        for (int i = 0; i < 128; i++)
            send(64'(i+1), 64'(i), 64'(-i), 64'(i), 1, i, i+1, i == 127, 0);
        send(64'd500, 64'd0, 64'd0, 64'd0, 0, 0, 0, 0, 0);
        step();
        chk("full_done", 64'(done),     64'd1);
        chk("full_wrc",  64'(wr_count), 64'd128);

        // gapped input, N=5
        do_arm(5, 0);
        for (int i = 0; i < 5; i++) begin
            send(64'(200+i), 64'(i), 64'(i), 64'(i), 1, i, i+1, i == 4, 0);
            step(); step();
        end
        send(64'd300, 64'd0, 64'd0, 64'd0, 0, 0, 0, 0, 0);
        send(64'd301, 64'd0, 64'd0, 64'd0, 0, 0, 0, 0, 0);
        step();
        chk("gap_done", 64'(done), 64'd1);

        // asynchronous reset mid-capture with din_valid high
        do_arm(8, 0);
        send(64'd11, 64'd0, 64'h0000_0100_0000_0000, 64'd0, 1, 0, 1, 0, 1);
        send(64'd12, 64'd0, 64'd0, 64'd0, 1, 1, 2, 0, 1);
        step();
        din_aa = 64'd13; din_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we",   64'(bram_we),     64'd0);
        chk("mid_rst_addr", 64'(bram_addr),   64'd0);
        chk("mid_rst_aa",   64'(bram_aa),     64'd0);
        chk("mid_rst_busy", 64'(busy),        64'd0);
        chk("mid_rst_done", 64'(done),        64'd0);
        chk("mid_rst_wrc",  64'(wr_count),    64'd0);
        chk("mid_rst_sat",  64'(sat_warning), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        din_valid = 1'b0;
        step(); step(); step();

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
